// File: rtl/flexbex_efpga_pkg.sv
// Shared definitions for the custom-0 eFPGA sequencer:
// FSM states, claimed opcode and instruction field positions.
package flexbex_efpga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } efpga_state_e;

    localparam logic [6:0] CUST_OPC = 7'h0b;

    localparam int unsigned CH_LSB    = 29;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned DELAY_LSB = 25;
    localparam int unsigned FUNCT_BIT = 14;
    localparam int unsigned OPER_LSB  = 12;
    localparam int unsigned RD_LSB    = 7;

endpackage

// File: rtl/flexbex_efpga_delay_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module flexbex_efpga_delay_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flexbex_ibex_efpga_seq_decoder.sv
// Custom-0 eFPGA sequencer: decode, issue to a channel, time, write back.
// Optional FLEXBEX_EFPGA_DONE_EN adds per-channel early-done inputs.
module flexbex_ibex_efpga_seq_decoder #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DELAY_W  = 4,
    parameter int unsigned DATA_W   = 32,
    parameter logic [6:0]  CUST_OPC = flexbex_efpga_pkg::CUST_OPC
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     instr_valid_i,
    input  logic [31:0]              instr_rdata_i,
    input  logic                     deassert_we_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        rs1_data_i,
    input  logic [DATA_W-1:0]        rs2_data_i,
    output logic                     efpga_req_o,
    output logic [2:0]               efpga_ch_o,
    output logic [1:0]               efpga_operator_o,
    output logic [DATA_W-1:0]        efpga_op_a_o,
    output logic [DATA_W-1:0]        efpga_op_b_o,
    input  logic [NUM_CH*DATA_W-1:0] efpga_result_i,
`ifdef FLEXBEX_EFPGA_DONE_EN
    input  logic [NUM_CH-1:0]        efpga_done_i,
`endif
    output logic                     id_stall_o,
    output logic                     illegal_insn_o,
    output logic                     wb_we_o,
    output logic [4:0]               wb_waddr_o,
    output logic [DATA_W-1:0]        wb_wdata_o,
    output logic                     busy_o
);

    import flexbex_efpga_pkg::*;

    efpga_state_e state_q, state_d;

    logic [2:0]         ch_f;
    logic [DELAY_W-1:0] delay_f;
    logic               is_cust, legal, idle, accept, to_wb;
    logic               cnt_zero, done_hit;
    logic [DATA_W-1:0]  res_sel;

    logic [4:0]         rd_q;
    logic [DELAY_W-1:0] delay_q;
    logic               wb_we_q;
    logic               unused_instr;

    assign unused_instr = ^instr_rdata_i;

    assign ch_f    = instr_rdata_i[CH_LSB +: CH_W];
    assign delay_f = instr_rdata_i[DELAY_LSB +: DELAY_W];
    assign is_cust = (instr_rdata_i[6:0] == CUST_OPC);
    assign legal   = !instr_rdata_i[FUNCT_BIT] &&
                     ({1'b0, ch_f} < 4'(NUM_CH));
    assign idle    = (state_q == IDLE);

    assign accept = idle && instr_valid_i && is_cust && legal &&
                    !deassert_we_i && !flush_i;

    assign illegal_insn_o = idle && instr_valid_i && is_cust && !legal;
    assign busy_o         = !idle;
    assign id_stall_o     = accept || (state_q == ISSUE) ||
                            (state_q == WAIT);

    always_comb begin
        res_sel = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (efpga_ch_o == 3'(c)) begin
                res_sel = efpga_result_i[c*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FLEXBEX_EFPGA_DONE_EN
    always_comb begin
        done_hit = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (efpga_ch_o == 3'(c)) begin
                done_hit = efpga_done_i[c];
            end
        end
    end
`else
    assign done_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_zero || done_hit) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything once an operation is in flight
        if (flush_i && !idle) state_d = IDLE;
    end

    assign to_wb = (state_q == WAIT) && (state_d == WB);

    flexbex_efpga_delay_cnt #(
        .W (DELAY_W)
    ) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (flush_i && !idle),
        .load_i     (state_q == ISSUE),
        .load_val_i (delay_q),
        .dec_i      (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            efpga_req_o      <= 1'b0;
            efpga_ch_o       <= '0;
            efpga_operator_o <= '0;
            efpga_op_a_o     <= '0;
            efpga_op_b_o     <= '0;
            rd_q             <= '0;
            delay_q          <= '0;
            wb_we_q          <= 1'b0;
            wb_wdata_o       <= '0;
        end else begin
            state_q     <= state_d;
            efpga_req_o <= accept;
            if (accept) begin
                efpga_ch_o       <= ch_f;
                efpga_operator_o <= instr_rdata_i[OPER_LSB +: 2];
                efpga_op_a_o     <= rs1_data_i;
                efpga_op_b_o     <= rs2_data_i;
                rd_q             <= instr_rdata_i[RD_LSB +: 5];
                delay_q          <= delay_f;
            end
            wb_we_q <= to_wb && (rd_q != 5'd0);
            if (to_wb) wb_wdata_o <= res_sel;
        end
    end

    assign wb_waddr_o = rd_q;
    assign wb_we_o    = wb_we_q && !flush_i;

endmodule

// File: tb/tb_flexbex_ibex_efpga_seq_decoder.sv
// Bench for the custom-0 eFPGA sequencer: vector table, directed
// corner sequences and a randomized transaction-timeline model.
module tb_flexbex_ibex_efpga_seq_decoder;

    localparam int NUM_CH  = 4;
    localparam int DELAY_W = 4;
    localparam int DATA_W  = 32;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     instr_valid_i;
    logic [31:0]              instr_rdata_i;
    logic                     deassert_we_i;
    logic                     flush_i;
    logic [DATA_W-1:0]        rs1_data_i;
    logic [DATA_W-1:0]        rs2_data_i;
    logic                     efpga_req_o;
    logic [2:0]               efpga_ch_o;
    logic [1:0]               efpga_operator_o;
    logic [DATA_W-1:0]        efpga_op_a_o;
    logic [DATA_W-1:0]        efpga_op_b_o;
    logic [NUM_CH*DATA_W-1:0] efpga_result_i;
    logic                     id_stall_o;
    logic                     illegal_insn_o;
    logic                     wb_we_o;
    logic [4:0]               wb_waddr_o;
    logic [DATA_W-1:0]        wb_wdata_o;
    logic                     busy_o;
`ifdef FLEXBEX_EFPGA_DONE_EN
    logic [NUM_CH-1:0]        efpga_done_i;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] res [NUM_CH];

    always #5 clk_i = ~clk_i;

    flexbex_ibex_efpga_seq_decoder #(
        .NUM_CH  (NUM_CH),
        .DELAY_W (DELAY_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .instr_valid_i    (instr_valid_i),
        .instr_rdata_i    (instr_rdata_i),
        .deassert_we_i    (deassert_we_i),
        .flush_i          (flush_i),
        .rs1_data_i       (rs1_data_i),
        .rs2_data_i       (rs2_data_i),
        .efpga_req_o      (efpga_req_o),
        .efpga_ch_o       (efpga_ch_o),
        .efpga_operator_o (efpga_operator_o),
        .efpga_op_a_o     (efpga_op_a_o),
        .efpga_op_b_o     (efpga_op_b_o),
        .efpga_result_i   (efpga_result_i),
`ifdef FLEXBEX_EFPGA_DONE_EN
        .efpga_done_i     (efpga_done_i),
`endif
        .id_stall_o       (id_stall_o),
        .illegal_insn_o   (illegal_insn_o),
        .wb_we_o          (wb_we_o),
        .wb_waddr_o       (wb_waddr_o),
        .wb_wdata_o       (wb_wdata_o),
        .busy_o           (busy_o)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int ch, input int d,
                                       input int f14, input int op,
                                       input int rd, input int opc);
        return ((32'(ch) & 32'd7) << 29) | ((32'(d) & 32'd15) << 25) |
               ((32'(f14) & 32'd1) << 14) | ((32'(op) & 32'd3) << 12) |
               ((32'(rd) & 32'd31) << 7) | (32'(opc) & 32'd127);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v,
                         input logic dq, input logic fl);
        instr_rdata_i = ins;
        instr_valid_i = v;
        deassert_we_i = dq;
        flush_i       = fl;
    endtask

    task automatic set_res();
        for (int c = 0; c < NUM_CH; c++) begin
            res[c] = $urandom;
            efpga_result_i[c*DATA_W +: DATA_W] = res[c];
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req"}, 64'(efpga_req_o), 0);
        chk({tag, " ch"}, 64'(efpga_ch_o), 0);
        chk({tag, " oper"}, 64'(efpga_operator_o), 0);
        chk({tag, " op_a"}, 64'(efpga_op_a_o), 0);
        chk({tag, " op_b"}, 64'(efpga_op_b_o), 0);
        chk({tag, " wb_we"}, 64'(wb_we_o), 0);
        chk({tag, " waddr"}, 64'(wb_waddr_o), 0);
        chk({tag, " wdata"}, 64'(wb_wdata_o), 0);
        chk({tag, " busy"}, 64'(busy_o), 0);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic        v, dq, fl;
        logic        ill, acc;
    } vec_t;

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        rs1_data_i = '0;
        rs2_data_i = '0;
        efpga_result_i = '0;
`ifdef FLEXBEX_EFPGA_DONE_EN
        efpga_done_i = '0;
`endif
        set_res();
        repeat (3) @(posedge clk_i);
        #1;
        chk_zero("reset");
        chk("reset stall", 64'(id_stall_o), 0);
        rst_ni = 1'b1;
        tick();

        // Decode table, presented in IDLE
        tv[0] = '{"legal ch2", mk(2,3,0,1,5,'h0b), 1,0,0, 0,1};
        tv[1] = '{"ch5", mk(5,3,0,1,5,'h0b), 1,0,0, 1,0};
        tv[2] = '{"f14", mk(1,0,1,2,6,'h0b), 1,0,0, 1,0};
        tv[3] = '{"ch7", mk(7,1,0,0,1,'h0b), 1,0,0, 1,0};
        tv[4] = '{"deassert", mk(3,2,0,3,4,'h0b), 1,1,0, 0,0};
        tv[5] = '{"flush", mk(3,2,0,3,4,'h0b), 1,0,1, 0,0};
        tv[6] = '{"novalid", mk(1,2,0,3,4,'h0b), 0,0,0, 0,0};
        tv[7] = '{"other opc", mk(5,2,1,3,4,'h33), 1,0,0, 0,0};
        tv[8] = '{"legal ch0", mk(0,0,0,0,0,'h0b), 1,0,0, 0,1};
        tv[9] = '{"ch5 novalid", mk(5,0,0,0,2,'h0b), 0,0,0, 0,0};

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].instr, tv[i].v, tv[i].dq, tv[i].fl);
            #2;
            chk({tv[i].nm, " illegal"}, 64'(illegal_insn_o), 64'(tv[i].ill));
            chk({tv[i].nm, " stall"}, 64'(id_stall_o), 64'(tv[i].acc));
            tick();
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            #2;
            chk({tv[i].nm, " busy"}, 64'(busy_o), 64'(tv[i].acc));
            if (tv[i].acc) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                #2;
                chk({tv[i].nm, " flushed"}, 64'(busy_o), 0);
            end
            tick();
        end

        // Directed: ch2 op1 d3 rd5, writeback six cycles after accept
        set_res();
        drive(mk(2,3,0,1,5,'h0b), 1'b1, 1'b0, 1'b0);
        rs1_data_i = 32'h10;
        rs2_data_i = 32'h20;
        #2;
        chk("dir accept stall", 64'(id_stall_o), 1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        rs1_data_i = '0;
        rs2_data_i = '0;
        for (int k = 1; k <= 7; k++) begin
            #2;
            chk($sformatf("dir req k%0d", k), 64'(efpga_req_o), 64'(k == 1));
            chk($sformatf("dir we k%0d", k), 64'(wb_we_o), 64'(k == 6));
            chk($sformatf("dir busy k%0d", k), 64'(busy_o), 64'(k <= 6));
            chk($sformatf("dir stall k%0d", k), 64'(id_stall_o), 64'(k <= 5));
            if (k == 1) begin
                chk("dir ch", 64'(efpga_ch_o), 2);
                chk("dir oper", 64'(efpga_operator_o), 1);
                chk("dir op_a", 64'(efpga_op_a_o), 64'h10);
                chk("dir op_b", 64'(efpga_op_b_o), 64'h20);
            end
            if (k == 6) begin
                chk("dir waddr", 64'(wb_waddr_o), 5);
                chk("dir wdata", 64'(wb_wdata_o), 64'(res[2]));
            end
            tick();
        end

        // Flush at N+3 aborts, no writeback ever
        drive(mk(1,5,0,0,3,'h0b), 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        flush_i = 1'b1;
        #2;
        chk("flsh busy n3", 64'(busy_o), 1);
        tick();
        flush_i = 1'b0;
        for (int k = 4; k <= 12; k++) begin
            #2;
            chk($sformatf("flsh busy k%0d", k), 64'(busy_o), 0);
            chk($sformatf("flsh we k%0d", k), 64'(wb_we_o), 0);
            tick();
        end

        // rd=x0 d=0, then a back-to-back instruction held from WB
        drive(mk(3,0,0,2,0,'h0b), 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(mk(1,2,0,2,7,'h0b), 1'b1, 1'b0, 1'b0);
        #2;
        chk("x0 wb busy", 64'(busy_o), 1);
        chk("x0 wb we", 64'(wb_we_o), 0);
        chk("x0 wb stall", 64'(id_stall_o), 0);
        chk("x0 wb illegal", 64'(illegal_insn_o), 0);
        tick();
        #2;
        chk("b2b idle busy", 64'(busy_o), 0);
        chk("b2b accept", 64'(id_stall_o), 1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("b2b req", 64'(efpga_req_o), 1);
        chk("b2b ch", 64'(efpga_ch_o), 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // Flush during WB kills the write strobe that same cycle
        drive(mk(0,1,0,0,9,'h0b), 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        #2;
        chk("wbflush pre we", 64'(wb_we_o), 1);
        flush_i = 1'b1;
        #1;
        chk("wbflush we", 64'(wb_we_o), 0);
        tick();
        flush_i = 1'b0;
        #2;
        chk("wbflush busy", 64'(busy_o), 0);
        chk("wbflush we after", 64'(wb_we_o), 0);
        tick();

        // Async reset in the middle of WAIT
        drive(mk(2,10,0,3,4,'h0b), 1'b1, 1'b0, 1'b0);
        rs1_data_i = 32'hdead;
        rs2_data_i = 32'hbeef;
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        chk("rst pre busy", 64'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #2;
            chk($sformatf("postrst we k%0d", k), 64'(wb_we_o), 0);
            chk($sformatf("postrst busy k%0d", k), 64'(busy_o), 0);
            tick();
        end

`ifdef FLEXBEX_EFPGA_DONE_EN
        // Early done: ignored in ISSUE, honoured in WAIT
        set_res();
        drive(mk(1,15,0,0,8,'h0b), 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        efpga_done_i = 4'b0010;
        #2;
        chk("done issue req", 64'(efpga_req_o), 1);
        tick();
        efpga_done_i = '0;
        #2;
        chk("done ignored", 64'(busy_o), 1);
        tick();
        tick();
        efpga_done_i = 4'b0010;
        tick();
        efpga_done_i = '0;
        #2;
        chk("done wb we", 64'(wb_we_o), 1);
        chk("done wdata", 64'(wb_wdata_o), 64'(res[1]));
        tick();
        #2;
        chk("done idle", 64'(busy_o), 0);
        tick();
`endif

        // Randomized transactions against a timeline model
        for (int t = 0; t < 60; t++) begin
            int ch, d, rd, op, f14, opc, len, fk;
            bit dq, fl0, custom, legal, acc, ill;
            logic [31:0] a, b;
            ch  = $urandom_range(0, 7);
            d   = $urandom_range(0, 15);
            rd  = $urandom_range(0, 31);
            op  = $urandom_range(0, 3);
            f14 = ($urandom_range(0, 4) == 0) ? 1 : 0;
            opc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : 'h0b;
            dq  = ($urandom_range(0, 5) == 0);
            fl0 = ($urandom_range(0, 7) == 0);
            custom = (opc == 'h0b);
            legal  = (ch < NUM_CH) && (f14 == 0);
            acc    = custom && legal && !dq && !fl0;
            ill    = custom && !legal;
            len    = 3 + d;
            fk     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            a = $urandom;
            b = $urandom;
            set_res();
            drive(mk(ch, d, f14, op, rd, opc), 1'b1, dq, fl0);
            rs1_data_i = a;
            rs2_data_i = b;
            #2;
            chk($sformatf("rnd%0d illegal", t), 64'(illegal_insn_o), 64'(ill));
            chk($sformatf("rnd%0d stall0", t), 64'(id_stall_o), 64'(acc));
            tick();
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            if (acc) begin
                for (int k = 1; k <= len + 1; k++) begin
                    bit live;
                    live = (fk == 0) || (k <= fk);
                    deassert_we_i = 1'($urandom_range(0, 1));
                    flush_i = (k == fk);
                    #2;
                    chk($sformatf("rnd%0d busy k%0d", t, k),
                        64'(busy_o), 64'(k <= len && live));
                    chk($sformatf("rnd%0d req k%0d", t, k),
                        64'(efpga_req_o), 64'(k == 1));
                    chk($sformatf("rnd%0d stall k%0d", t, k),
                        64'(id_stall_o), 64'(k <= len - 1 && live));
                    chk($sformatf("rnd%0d we k%0d", t, k), 64'(wb_we_o),
                        64'(k == len && rd != 0 && fk == 0));
                    if (k == 1) begin
                        chk($sformatf("rnd%0d ch", t), 64'(efpga_ch_o), 64'(ch));
                        chk($sformatf("rnd%0d oper", t),
                            64'(efpga_operator_o), 64'(op));
                        chk($sformatf("rnd%0d op_a", t), 64'(efpga_op_a_o), 64'(a));
                        chk($sformatf("rnd%0d op_b", t), 64'(efpga_op_b_o), 64'(b));
                    end
                    if (k == len && rd != 0 && fk == 0) begin
                        chk($sformatf("rnd%0d waddr", t), 64'(wb_waddr_o), 64'(rd));
                        chk($sformatf("rnd%0d wdata", t),
                            64'(wb_wdata_o), 64'(res[ch]));
                    end
                    tick();
                end
                drive(32'h0, 1'b0, 1'b0, 1'b0);
            end else begin
                #2;
                chk($sformatf("rnd%0d idle", t), 64'(busy_o), 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
